// File: rtl/bitmask_encoder.sv
// Serial bitmask-to-index encoder: captures a WIDTH-bit mask and emits the index of every set bit, one per handshake.
// Optional ENC_ONEHOT_CHECK_EN adds an err pulse for captured masks that are not exactly one-hot.
module bitmask_encoder #(
  parameter int WIDTH     = 4,
  parameter int IDX_W     = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic             busy
`ifdef ENC_ONEHOT_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_pend;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;

  logic             w_capture;
  logic [WIDTH-1:0] w_src;
  logic [IDX_W-1:0] w_pick;
  logic [WIDTH-1:0] w_pick_oh;
  logic [WIDTH-1:0] w_rest;
  logic             w_single;

  // Selects the first set bit in emission order; the last hit in the scan wins.
  function automatic logic [IDX_W-1:0] f_pick(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] sel;
    sel = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (v[i]) sel = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) sel = IDX_W'(i);
      end
    end
    return sel;
  endfunction

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_EMIT);
  assign out_valid = r_out_valid;
  assign idx       = r_idx;
  assign last      = r_last;

  assign w_capture = in_valid && in_ready;

  // Capture and advance share one picker: the source is the new mask in IDLE, the remainder in EMIT.
  assign w_src     = (r_state == ST_IDLE) ? mask : r_pend;
  assign w_pick    = f_pick(w_src);
  assign w_pick_oh = {{(WIDTH-1){1'b0}}, 1'b1} << w_pick;
  assign w_rest    = w_src & ~w_pick_oh;
  assign w_single  = (w_src != '0) && (w_rest == '0);

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture && (w_src != '0)) begin
            r_pend      <= w_rest;
            r_idx       <= w_pick;
            r_last      <= w_single;
            r_out_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (r_out_valid && out_ready) begin
            if (r_last) begin
              r_out_valid <= 1'b0;
              r_last      <= 1'b0;
              r_pend      <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_idx  <= w_pick;
              r_pend <= w_rest;
              r_last <= w_single;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_last      <= 1'b0;
          r_pend      <= '0;
        end
      endcase
    end
  end

`ifdef ENC_ONEHOT_CHECK_EN
  logic r_err;

  // Zero masks also flag: they are dropped but still not one-hot.
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_capture && !w_single;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_bitmask_encoder.sv
// Directed bench for bitmask_encoder: an LSB-first and an MSB-first instance share stimulus, outputs checked against hand-computed values.
module tb_bitmask_encoder;

  logic       clk_i = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [3:0] mask;
  logic       out_ready;

  logic       in_ready, out_valid, last, busy;
  logic [1:0] idx;
  logic       m_in_ready, m_out_valid, m_last, m_busy;
  logic [1:0] m_idx;
`ifdef ENC_ONEHOT_CHECK_EN
  logic       err, m_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  bitmask_encoder #(.WIDTH(4), .IDX_W(2), .LSB_FIRST(1'b1)) dut (
    .clk_i(clk_i), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .idx(idx), .last(last), .busy(busy)
`ifdef ENC_ONEHOT_CHECK_EN
    , .err(err)
`endif
  );

  bitmask_encoder #(.WIDTH(4), .IDX_W(2), .LSB_FIRST(1'b0)) dut_msb (
    .clk_i(clk_i), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(m_in_ready), .mask(mask),
    .out_valid(m_out_valid), .out_ready(out_ready),
    .idx(m_idx), .last(m_last), .busy(m_busy)
`ifdef ENC_ONEHOT_CHECK_EN
    , .err(m_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic capture(input logic [3:0] m);
    in_valid = 1'b1;
    mask     = m;
    tick();
    in_valid = 1'b0;
    mask     = 4'b0000;
  endtask

  task automatic beat(input string tag, input logic [1:0] e_idx, input logic e_last);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".idx"},   32'(idx),       32'(e_idx));
    chk({tag, ".last"},  32'(last),      32'(e_last));
    chk({tag, ".rdy"},   32'(in_ready),  32'd0);
  endtask

  task automatic mbeat(input string tag, input logic [1:0] e_idx, input logic e_last);
    chk({tag, ".m_valid"}, 32'(m_out_valid), 32'd1);
    chk({tag, ".m_idx"},   32'(m_idx),       32'(e_idx));
    chk({tag, ".m_last"},  32'(m_last),      32'(e_last));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy"},   32'(in_ready),  32'd1);
    chk({tag, ".busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    mask      = 4'b0000;
    out_ready = 1'b0;
    tick();
    tick();
    idle_chk("reset");
    chk("reset.idx",  32'(idx),  32'd0);
    chk("reset.last", 32'(last), 32'd0);
    chk("reset.m_valid", 32'(m_out_valid), 32'd0);
    reset_n = 1'b1;
    tick();

    // single bit
    out_ready = 1'b1;
    capture(4'b0100);
    beat("t1", 2'd2, 1'b1);
    chk("t1.busy", 32'(busy), 32'd1);
    mbeat("t1", 2'd2, 1'b1);
    tick();
    idle_chk("t1.end");
    chk("t1.end.last", 32'(last), 32'd0);

    // multi-hot, both orders
    capture(4'b1011);
    beat("t2.b0", 2'd0, 1'b0); mbeat("t2.b0", 2'd3, 1'b0);
    tick();
    beat("t2.b1", 2'd1, 1'b0); mbeat("t2.b1", 2'd1, 1'b0);
    tick();
    beat("t2.b2", 2'd3, 1'b1); mbeat("t2.b2", 2'd0, 1'b1);
    tick();
    idle_chk("t2.end");

    // backpressure holds the beat
    out_ready = 1'b0;
    capture(4'b0110);
    beat("t3.h0", 2'd1, 1'b0);
    tick();
    beat("t3.h1", 2'd1, 1'b0);
    tick();
    beat("t3.h2", 2'd1, 1'b0);
    out_ready = 1'b1;
    tick();
    beat("t3.b1", 2'd2, 1'b1);
    tick();
    idle_chk("t3.end");

    // zero mask dropped, then two-hot
    capture(4'b0000);
    idle_chk("t4.zero");
`ifdef ENC_ONEHOT_CHECK_EN
    chk("t4.err_zero", 32'(err), 32'd1);
`endif
    tick();
    idle_chk("t4.zero2");
`ifdef ENC_ONEHOT_CHECK_EN
    chk("t4.err_clr", 32'(err), 32'd0);
`endif
    capture(4'b0011);
    beat("t4.b0", 2'd0, 1'b0);
`ifdef ENC_ONEHOT_CHECK_EN
    chk("t4.err_multi", 32'(err), 32'd1);
`endif
    tick();
    beat("t4.b1", 2'd1, 1'b1);
`ifdef ENC_ONEHOT_CHECK_EN
    chk("t4.err_multi_clr", 32'(err), 32'd0);
`endif
    tick();
    idle_chk("t4.end");

    // all ones: full sweep
    capture(4'b1111);
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("all.b%0d", i), 2'(i), (i == 3));
      mbeat($sformatf("all.b%0d", i), 2'(3 - i), (i == 3));
      tick();
    end
    idle_chk("all.end");

    // reset mid-operation
    capture(4'b1111);
    beat("t5.b0", 2'd0, 1'b0);
    tick();
    beat("t5.b1", 2'd1, 1'b0);
    reset_n = 1'b0;
    tick();
    idle_chk("t5.rst");
    chk("t5.rst.idx",  32'(idx),  32'd0);
    chk("t5.rst.last", 32'(last), 32'd0);
    reset_n = 1'b1;
    capture(4'b1000);
    beat("t5.top", 2'd3, 1'b1);
    mbeat("t5.top", 2'd3, 1'b1);
    tick();
    idle_chk("t5.end");

    // offer during EMIT is ignored until idle
    capture(4'b1010);
    beat("t6.b0", 2'd1, 1'b0);
    in_valid = 1'b1;
    mask     = 4'b0001;
    tick();
    beat("t6.b1", 2'd3, 1'b1);
    tick();
    idle_chk("t6.gap");
    tick();
    in_valid = 1'b0;
    mask     = 4'b0000;
    beat("t6.new", 2'd0, 1'b1);
    tick();
    idle_chk("t6.end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
